cache_mem_arbiter: RTL and testbench

- Shares the single sram-like memory port between the instruction cache (I port) and the data cache (D port).
- Both masters speak the same req/wr/size/addr/wdata → addr_ok/data_ok handshake that the caches drive toward memory.
- The arbiter sits between the two caches and the AXI bridge.
- It permits one outstanding transaction at a time, locks the owner from grant through data_ok, and routes responses only to the owner.

---
 rtl/cache_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Two-master (I-cache / D-cache) arbiter onto a single sram-like memory port.
// Define CACHE_ARB_RR_EN for round-robin arbitration; the default is fixed D-over-I priority.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic                  i_wr,
    input  logic [1:0]            i_size,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_addr_ok,
    output logic                  i_data_ok,

    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [1:0]            d_size,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_addr_ok,
    output logic                  d_data_ok,

    output logic                  m_req,
    output logic                  m_wr,
    output logic [1:0]            m_size,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok,

    output logic                  busy,
    output logic                  owner
);

    // Handshake: a master holds req (and its fields) until it sees addr_ok;
    // data_ok is a one-cycle pulse ending the transaction. Only one in flight.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nx;
    logic       win_d;
    logic       idle_grant;
    logic       sel;
    logic       addr_acc;
    logic       data_acc;

`ifdef CACHE_ARB_RR_EN
    logic rr_ptr;
    // Pointer only matters when both request; a lone requester always wins.
    assign win_d = d_req & (~i_req | rr_ptr);
`else
    assign win_d = d_req;
`endif

    assign idle_grant = (state == S_IDLE) && (i_req || d_req);
    assign sel        = idle_grant ? win_d : owner;

    assign m_wr    = sel ? d_wr    : i_wr;
    assign m_size  = sel ? d_size  : i_size;
    assign m_addr  = sel ? d_addr  : i_addr;
    assign m_wdata = sel ? d_wdata : i_wdata;

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    always_comb begin
        state_nx = state;
        m_req    = 1'b0;
        addr_acc = 1'b0;
        data_acc = 1'b0;
        case (state)
            S_IDLE: begin
                if (idle_grant) begin
                    m_req    = 1'b1;
                    addr_acc = m_addr_ok;
                    state_nx = m_addr_ok ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                m_req = sel ? d_req : i_req;
                if (m_addr_ok) begin
                    addr_acc = 1'b1;
                    if (m_data_ok) begin
                        data_acc = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (m_data_ok) begin
                    data_acc = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Nothing may pulse during the reset cycle.
        if (rst) begin
            m_req    = 1'b0;
            addr_acc = 1'b0;
            data_acc = 1'b0;
        end
    end

    assign i_addr_ok = addr_acc & ~sel;
    assign d_addr_ok = addr_acc &  sel;
    assign i_data_ok = data_acc & ~sel;
    assign d_data_ok = data_acc &  sel;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            owner <= 1'b1;
        end else begin
            state <= state_nx;
            if (idle_grant)
                owner <= win_d;
        end
    end

`ifdef CACHE_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= 1'b1;
        else if (addr_acc)
            rr_ptr <= ~sel;
    end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios then randomized traffic,
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef CACHE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_req, i_wr, i_addr_ok, i_data_ok;
    logic [1:0]    i_size;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata, i_rdata;
    logic          d_req, d_wr, d_addr_ok, d_data_ok;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_wr, m_addr_ok, m_data_ok;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          busy, owner;

    // Master request state, index 0 = I-cache, 1 = D-cache.
    logic          mreq   [2];
    logic          mwr    [2];
    logic [1:0]    msize  [2];
    logic [AW-1:0] maddr  [2];
    logic [DW-1:0] mwdata [2];
    logic          mwait  [2];
    logic          mdrop  [2];
    int            gap    [2];
    bit            auto_mode;
    bit            cont_mode;
    bit            rand_mem;
    bit            fast_mem;
    bit            model_push;

    assign i_req = mreq[0];   assign i_wr = mwr[0];   assign i_size = msize[0];
    assign i_addr = maddr[0]; assign i_wdata = mwdata[0];
    assign d_req = mreq[1];   assign d_wr = mwr[1];   assign d_size = msize[1];
    assign d_addr = maddr[1]; assign d_wdata = mwdata[1];

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .busy(busy), .owner(owner)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: is a transaction in flight, has its address been taken,
    // who owns the port, and which master round-robin favours (1 = D).
    logic txn_active, addr_done, owner_m, ptr_m;

    // Scoreboard of grant order (who received addr_ok), expected vs observed.
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_req(input int m);
        mreq[m]   = 1'b1;
        mwr[m]    = (m == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        msize[m]  = 2'($urandom_range(0, 3));
        maddr[m]  = $urandom;
        mwdata[m] = $urandom;
    endtask

    task automatic model_reset();
        txn_active = 1'b0;
        addr_done  = 1'b0;
        owner_m    = 1'b1;
        ptr_m      = 1'b1;
        for (int m = 0; m < 2; m++) begin
            mreq[m] = 1'b0; mwait[m] = 1'b0; mdrop[m] = 1'b0; gap[m] = 0;
        end
    endtask

    // One clock cycle. Called just after a rising edge; inputs change there,
    // outputs are checked on the falling edge, and it returns after the next rise.
    task automatic step(input logic aok_in, input logic dok_in, input logic [DW-1:0] rd);
        logic aok, dok, pend, win, sel, e_req;
        logic [1:0] e_aok, e_dok;
        for (int m = 0; m < 2; m++) begin
            if (mdrop[m]) begin
                mreq[m] = 1'b0;
                mdrop[m] = 1'b0;
            end
            if (auto_mode && !mreq[m] && !mwait[m]) begin
                if (gap[m] == 0) begin
                    new_req(m);
                    gap[m] = cont_mode ? 0 : $urandom_range(0, 4);
                end else begin
                    gap[m]--;
                end
            end
        end
        pend = !txn_active ? (mreq[0] | mreq[1]) : (!addr_done ? mreq[owner_m] : 1'b0);
        aok = aok_in;
        dok = dok_in;
        if (fast_mem) begin
            aok = pend;
            dok = txn_active & addr_done;
        end else if (rand_mem) begin
            aok = pend & ($urandom_range(0, 2) == 0);
            if (txn_active && addr_done)  dok = ($urandom_range(0, 1) == 0);
            else if (txn_active && aok)   dok = ($urandom_range(0, 3) == 0);
            else                          dok = ($urandom_range(0, 9) == 0);
        end
        m_addr_ok = aok;
        m_data_ok = dok;
        m_rdata   = rd;

        e_aok = 2'b00;
        e_dok = 2'b00;
        win   = 1'b0;
        if (!txn_active) begin
            if (mreq[0] | mreq[1]) begin
                win = (mreq[0] & mreq[1]) ? (RR ? ptr_m : 1'b1) : mreq[1];
                sel = win;
                e_req = 1'b1;
                if (aok) e_aok[win] = 1'b1;
            end else begin
                sel = owner_m;
                e_req = 1'b0;
            end
        end else if (!addr_done) begin
            sel = owner_m;
            e_req = mreq[owner_m];
            if (aok) begin
                e_aok[sel] = 1'b1;
                if (dok) e_dok[sel] = 1'b1;
            end
        end else begin
            sel = owner_m;
            e_req = 1'b0;
            if (dok) e_dok[sel] = 1'b1;
        end

        @(negedge clk);
        check("m_req",     m_req,     e_req);
        check("m_addr",    m_addr,    maddr[sel]);
        check("m_wr",      m_wr,      mwr[sel]);
        check("m_size",    m_size,    msize[sel]);
        check("m_wdata",   m_wdata,   mwdata[sel]);
        check("i_addr_ok", i_addr_ok, e_aok[0]);
        check("d_addr_ok", d_addr_ok, e_aok[1]);
        check("i_data_ok", i_data_ok, e_dok[0]);
        check("d_data_ok", d_data_ok, e_dok[1]);
        check("busy",      busy,      txn_active);
        check("owner",     owner,     owner_m);
        check("i_rdata",   i_rdata,   rd);
        check("d_rdata",   d_rdata,   rd);
        if (i_addr_ok) got_q.push_back(1'b0);
        if (d_addr_ok) got_q.push_back(1'b1);
        if (model_push) begin
            if (e_aok[0]) exp_q.push_back(1'b0);
            if (e_aok[1]) exp_q.push_back(1'b1);
        end

        if (!txn_active) begin
            if (mreq[0] | mreq[1]) begin
                owner_m = win;
                txn_active = 1'b1;
                addr_done = aok;
            end
        end else if (!addr_done) begin
            if (aok) begin
                if (dok) txn_active = 1'b0;
                else     addr_done = 1'b1;
            end
        end else if (dok) begin
            txn_active = 1'b0;
            addr_done = 1'b0;
        end
        if (e_aok != 2'b00) ptr_m = e_aok[1] ? 1'b0 : 1'b1;
        for (int m = 0; m < 2; m++) begin
            if (e_aok[m]) begin
                mdrop[m] = 1'b1;
                mwait[m] = 1'b1;
            end
            if (e_dok[m]) mwait[m] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int cyc;
        rst = 1'b1;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            mwr[m] = 1'b0; msize[m] = 2'd0; maddr[m] = '0; mwdata[m] = '0;
        end
        model_reset();
        auto_mode = 0; cont_mode = 0; rand_mem = 0; fast_mem = 0; model_push = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy",  busy,  1'b0);
        check("rst_owner", owner, 1'b1);
        check("rst_m_req", m_req, 1'b0);
        check("rst_oks",   {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 4'b0000);
        @(posedge clk);
        #1;

        // Single I read: addr_ok at cycle 2, data_ok at cycle 4
        mreq[0] = 1'b1; mwr[0] = 1'b0; msize[0] = 2'd2;
        maddr[0] = 32'hBFC0_0000; mwdata[0] = '0;
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);
        step(1, 0, 32'h0);
        step(0, 0, 32'h0);
        step(0, 1, 32'h2408_0001);
        exp_q.push_back(1'b0);

        // D write-back
        mreq[1] = 1'b1; mwr[1] = 1'b1; msize[1] = 2'd2;
        maddr[1] = 32'h0000_1230; mwdata[1] = 32'hDEAD_BEEF;
        step(0, 0, $urandom);
        step(0, 0, $urandom);
        step(1, 0, $urandom);
        step(0, 0, $urandom);
        step(0, 1, $urandom);
        exp_q.push_back(1'b1);

        // Lock: I raises req while D sits waiting for addr_ok
        new_req(1);
        step(0, 0, $urandom);
        new_req(0);
        step(0, 0, $urandom);
        step(1, 0, $urandom);
        step(0, 1, $urandom);
        step(1, 0, $urandom);
        step(0, 1, $urandom);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);

        // Both masters requesting continuously: four grants, then drain
        new_req(0);
        new_req(1);
        auto_mode = 1; cont_mode = 1; fast_mem = 1;
        n0 = got_q.size();
        cyc = 0;
        while (got_q.size() < n0 + 4 && cyc < 60) begin
            step(0, 0, $urandom);
            cyc++;
        end
        check("cont_grants", got_q.size() - n0, 4);
        auto_mode = 0;
        cyc = 0;
        while ((txn_active || mreq[0] || mreq[1] || mdrop[0] || mdrop[1]) && cyc < 20) begin
            step(0, 0, $urandom);
            cyc++;
        end
        fast_mem = 0; cont_mode = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(RR ? 1'(k % 2 == 0) : 1'b1);
        exp_q.push_back(RR ? 1'b1 : 1'b0);

        // Reset while in DATA; a later data_ok must not pulse anything
        new_req(1);
        step(1, 0, $urandom);
        exp_q.push_back(1'b1);
        rst = 1'b1;
        mreq[0] = 1'b0; mreq[1] = 1'b0;
        m_data_ok = 1'b1; m_addr_ok = 1'b0;
        @(negedge clk);
        check("rstmid_d_data_ok", d_data_ok, 1'b0);
        check("rstmid_i_data_ok", i_data_ok, 1'b0);
        check("rstmid_m_req", m_req, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step(0, 1, $urandom);
        step(0, 1, $urandom);

        // Randomized traffic
        auto_mode = 1; rand_mem = 1; model_push = 1;
        repeat (1500) step(0, 0, $urandom);
        auto_mode = 0;
        cyc = 0;
        while ((txn_active || mreq[0] || mreq[1] || mdrop[0] || mdrop[1]) && cyc < 300) begin
            step(0, 0, $urandom);
            cyc++;
        end
        check("drain", {31'd0, txn_active}, 32'd0);

        check("grant_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check("grant_order", got_q[k], exp_q[k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
